// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-port arbiter for an async FIFO: grants one consumer at a
// time for bursts of up to MAX_BURST pops and steers returned data back.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] out_valid_q, out_valid_d;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               pop;
  logic               last_pop;

  // Round-robin pick: first set request scanning last+1, last+2, ... wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    winner = last_q;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[IDX_W'((int'(last_q) + k) % NUM_REQ)]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // Pop strobe is combinational from registered state, masked during reset.
  assign pop      = !rrst && (state_q == BURST) && req[owner_q] && !empty;
  assign last_pop = pop && (count_q + CNT_W'(1) == CNT_W'(MAX_BURST));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    count_d     = count_q;
    out_valid_d = pop ? gnt_q : '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          gnt_d   = NUM_REQ'(1) << winner;
          owner_d = winner;
          last_d  = winner;
          count_d = '0;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (pop) begin
          count_d = count_q + CNT_W'(1);
          if (last_pop) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      count_q     <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign r_en      = pop;
  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = (|out_valid_q) ? r_data : '0;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized scoreboard bench for fifo_rd_arbiter against a grant/burst
// reference model; returned data is matched by a separate monitor.
module tb_fifo_rd_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          r_clk = 1'b0;
  logic          rrst;
  logic [N-1:0]  req;
  logic          empty;
  logic [DW-1:0] r_data;
  logic          r_en;
  logic [N-1:0]  gnt;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic          busy;

  fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .r_clk     (r_clk),
    .rrst      (rrst),
    .req       (req),
    .empty     (empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    int            cons;
    logic [DW-1:0] data;
  } ret_t;

  ret_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: who holds the port, how many pops it has had, and the
  // consumer that won most recently.
  bit m_granted;
  int m_owner;
  int m_pops;
  int m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_granted = 1'b0;
    m_owner   = 0;
    m_pops    = 0;
    m_last    = N - 1;
  endtask

  // One read-clock cycle, entered and left at the falling edge.
  task automatic step(input logic rst_v, input logic [N-1:0] req_v, input logic empty_v);
    logic [N-1:0]  exp_gnt;
    logic          exp_ren;
    logic [DW-1:0] d;
    rrst  = rst_v;
    req   = req_v;
    empty = empty_v;
    #1;
    exp_gnt = m_granted ? N'(1) << m_owner : '0;
    exp_ren = !rst_v && m_granted && req_v[m_owner] && !empty_v;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("r_en", 32'(r_en), 32'(exp_ren));
    check("busy", 32'(busy), 32'(m_granted));
    d = DW'($urandom);
    if (rst_v) begin
      model_reset();
    end else if (m_granted) begin
      if (!req_v[m_owner]) begin
        m_granted = 1'b0;
      end else if (exp_ren) begin
        sb_q.push_back('{cons: m_owner, data: d});
        m_pops++;
        if (m_pops == MB) m_granted = 1'b0;
      end
    end else if (req_v != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (!m_granted && req_v[(m_last + k) % N]) begin
          m_owner   = (m_last + k) % N;
          m_granted = 1'b1;
        end
      end
      m_last = m_owner;
      m_pops = 0;
    end
    @(posedge r_clk);
    #1;
    // A popped entry appears on r_data the next cycle; otherwise drive noise.
    r_data = exp_ren ? d : DW'($urandom);
    @(negedge r_clk);
  endtask

  // Monitor: every out_valid beat must match the oldest outstanding pop.
  always @(negedge r_clk) begin
    if (mon_en) begin
      if (out_valid != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'h0);
        end else begin
          ret_t e;
          e = sb_q.pop_front();
          check("out_valid", 32'(out_valid), 32'(N'(1) << e.cons));
          check("out_data", 32'(out_data), 32'(e.data));
        end
      end else begin
        check("out_data_idle", 32'(out_data), 32'h0);
      end
    end
  end

  initial begin
    logic [N-1:0] prev_gnt;
    logic [N-1:0] order_q[$];
    logic [N-1:0] exp_order[5];
    logic [N-1:0] rq;
    logic         rs;
    logic         em;

    rrst   = 1'b1;
    req    = '1;
    empty  = 1'b0;
    r_data = '0;
    model_reset();
    @(negedge r_clk);
    mon_en = 1'b1;

    // Reset held with all requesting, then fairness under full load.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    prev_gnt = '0;
    for (int c = 0; c < 24; c++) begin
      step(1'b0, 4'b1111, 1'b0);
      if (gnt != '0 && prev_gnt == '0) order_q.push_back(gnt);
      prev_gnt = gnt;
    end
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check("grant_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      check("grant_order", 32'(order_q[i]), 32'(exp_order[i]));

    // Single consumer with an empty stall after the second pop.
    step(1'b1, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b0001, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0001, 1'b0);

    // Early release: consumer 0 drops after two pops, consumer 1 is next.
    step(1'b1, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    check("early_release_next_gnt", 32'(gnt), 32'b0010);
    for (int c = 0; c < 4; c++) step(1'b0, 4'b0010, 1'b0);

    // Reset in the cycle after the first pop restores the pointer.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b1, 4'b1010, 1'b0);
    check("reset_kills_valid", 32'(out_valid), 32'h0);
    step(1'b0, 4'b1010, 1'b0);
    check("post_reset_winner", 32'(gnt), 32'b0010);

    // Random traffic: slowly changing requests, sporadic empty and reset.
    rq = 4'b1010;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      rs = ($urandom_range(99) == 0);
      em = ($urandom_range(3) == 0);
      step(rs, rq, em);
    end

    for (int c = 0; c < 4; c++) step(1'b0, 4'b0000, 1'b0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the async FIFO among NUM_REQ consumers in the read clock domain.
- Grants one consumer at a time for a burst of up to MAX_BURST pops.
- Drives r_en only when the FIFO is not empty.
- Steers returned read data to the granted consumer with a one-hot valid.

Parameters:
NUM_REQ, 4, number of consumers sharing the read port (>=2)
DATA_WIDTH, 8, FIFO data width
MAX_BURST, 4, maximum pops per grant (>=1); burst counter width CNT_W = $clog2(MAX_BURST+1)

Ports:
r_clk  input  1  read-domain clock; all logic on rising edge
rrst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-consumer request; level, held while the consumer wants data
empty  input  1  registered empty flag from the FIFO read-pointer logic
r_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an r_en pop
r_en  output  1  FIFO pop strobe
gnt  output  NUM_REQ  one-hot grant; all zero when idle
out_valid  output  NUM_REQ  one-hot; bit i high = out_data belongs to consumer i this cycle
out_data  output  DATA_WIDTH  r_data when any out_valid bit is high, else 0
busy  output  1  high when state != IDLE

Behaviour:
Reset (rrst=1 at a clock edge):
- state=IDLE, gnt=0, count=0, out_valid=0, out_data=0, busy=0.
- Round-robin pointer last=NUM_REQ-1, so consumer 0 has top priority after reset.
- r_en is 0 during reset. It is combinational from registered state and is forced low while rrst=1.
- A burst in progress is abandoned. Data popped in the reset cycle is discarded: out_valid stays 0 the following cycle.

State machine, IDLE / BURST:
- IDLE:
  - If req != 0, pick the first set req bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Register gnt=onehot(winner), owner=winner, last=winner, count=0, then go to BURST.
  - The first pop can occur in the cycle after req is first seen (1-cycle arbitration latency).
  - If req=0, stay in IDLE.
- BURST:
  - r_en = req[owner] & !empty.
  - On each r_en cycle, count increments.
  - Exit to IDLE at the edge after a pop that makes count == MAX_BURST.
  - Exit to IDLE at the edge of any cycle where req[owner]=0; r_en is 0 in that cycle.
  - On exit, gnt clears to 0. IDLE always lasts exactly one cycle before the next grant, even if req stays high.
- empty=1 while in BURST: no pop, count holds, gnt holds, and there is no timeout.
- Requests from other consumers never pre-empt a burst.

Data return:
- out_valid is a registered copy of (r_en ? gnt : 0), so it is asserted exactly 1 cycle after each pop.
- out_data = r_data gated by |out_valid.
- A pop made in the last cycle of a burst (or the cycle before req drops) still produces its out_valid the next cycle, even though gnt is already 0 or has moved on.

Arithmetic:
- count is CNT_W bits wide and never exceeds MAX_BURST.
- The round-robin index wraps modulo NUM_REQ.
- At most one pop per cycle. The block never pops when empty=1.

Test Plan:
- Reset: rrst=1 for 2 cycles with req=4'b1111 and empty=0 -> gnt=0, r_en=0, out_valid=0, out_data=0, busy=0 throughout; release -> gnt=4'b0001 one cycle later.
- Single burst: req=4'b0001, FIFO holding 10 entries (empty=0) -> gnt=0001 at cycle 1; r_en high cycles 1-4; out_valid=0001 cycles 2-5 with out_data = entries 0-3; gnt=0 at cycle 5 (IDLE); regrant 0001 at cycle 6.
- Fairness: req=4'b1111 held, FIFO never empty -> grant order 0001, 0010, 0100, 1000, 0001; each grant gets exactly 4 pops; one idle cycle between bursts.
- Empty stall: req=0001, empty=1 for 3 cycles after the 2nd pop -> r_en low for those 3 cycles, gnt stays 0001, busy=1; burst finishes with exactly 4 pops total.
- Early release: req=4'b0011, consumer 0 drops req after 2 pops -> r_en=0 that cycle; out_valid=0001 for the 2nd pop still appears; next grant is 0010.
- Reset mid-burst: rrst=1 in the cycle after the 1st pop -> out_valid=0 next cycle, all outputs 0; after release with req=4'b1010, the winner is 0010 because the pointer was reset.
